unidade_logica_nbits: RTL and testbench

// - Parametrised, pipelined bitwise logic unit; successor to the fixed 16-bit single-function gate arrays.
// - Computes one of 8 bitwise ops on two WIDTH-bit operands, selected per transaction.
// - Elastic 2-stage pipeline with valid/ready handshakes on both sides; also produces zero and all-ones flags.
// - Sits in the ULA datapath beside the adder/shifter; the ULA top muxes its outputs.
//

---
 rtl/unidade_logica_nbits.sv | 132 +++++++++++++
 tb/tb_unidade_logica_nbits.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_logica_nbits.sv
// unidade_logica_nbits: parametrised two-stage elastic bitwise logic unit.
//
// Computes one of eight bitwise operations on two WIDTH-bit operands and
// reports zero / all-ones flags (and optionally a popcount) of the result.
// Both sides use valid/ready handshakes. The pipeline holds at most two
// transactions. There is no skid buffer, so in_ready is combinational from
// out_ready.
//
// Optional feature macro: BITLOGIC_POPCNT_EN adds the contagem port, which
// carries the popcount of the result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   a, b and op are valid
//   in_ready   unit accepts a transaction this cycle (combinational)
//   a, b       WIDTH-bit operands (b ignored by op 110 / 111)
//   op         000 AND, 001 OR, 010 NOR, 011 XOR, 100 NAND, 101 XNOR,
//              110 NOT A, 111 pass A
//   out_valid  resultado and flags are valid
//   out_ready  downstream accepts the result
//   resultado  registered result
//   zero       resultado == 0
//   uns        resultado == all ones
//   contagem   popcount of resultado (BITLOGIC_POPCNT_EN only)
module unidade_logica_nbits #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [2:0]                 op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           resultado,
  output logic                       zero,
`ifdef BITLOGIC_POPCNT_EN
  output logic                       uns,
  output logic [$clog2(WIDTH+1)-1:0] contagem
`else
  output logic                       uns
`endif
);

`ifdef BITLOGIC_POPCNT_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);
`endif

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] res_c;

  // Elastic handshake: a stage loads when empty or when its contents move on
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Stage 1: capture operands; data only updates on a real transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= 3'b000;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op;
      end
    end
  end

  // Bitwise operation on the stage-1 registers
  always_comb begin
    res_c = '0;
    unique case (s1_op)
      3'b000:  res_c = s1_a & s1_b;
      3'b001:  res_c = s1_a | s1_b;
      3'b010:  res_c = ~(s1_a | s1_b);
      3'b011:  res_c = s1_a ^ s1_b;
      3'b100:  res_c = ~(s1_a & s1_b);
      3'b101:  res_c = ~(s1_a ^ s1_b);
      3'b110:  res_c = ~s1_a;
      default: res_c = s1_a;
    endcase
  end

`ifdef BITLOGIC_POPCNT_EN
  logic [CW-1:0] cnt_c;

  // Popcount of the result being loaded into stage 2
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_c = cnt_c + CW'(res_c[i]);
    end
  end
`endif

  // Stage 2: result and flags held stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      resultado <= '0;
      zero      <= 1'b1;
      uns       <= 1'b0;
`ifdef BITLOGIC_POPCNT_EN
      contagem  <= '0;
`endif
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        resultado <= res_c;
        zero      <= (res_c == '0);
        uns       <= &res_c;
`ifdef BITLOGIC_POPCNT_EN
        contagem  <= cnt_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_unidade_logica_nbits.sv
// Bench for unidade_logica_nbits: three instances (WIDTH 8/16/33) share
// one stimulus stream; a 33-bit reference model truncated per width
// predicts every result. Directed table vectors cover each op and the flags.
module tb_unidade_logica_nbits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  op;
  logic [32:0] a;
  logic [32:0] b;

  logic        ir8, ir16, ir33;
  logic        ov8, ov16, ov33;
  logic [7:0]  r8;
  logic [15:0] r16;
  logic [32:0] r33;
  logic        z8, z16, z33;
  logic        u8, u16, u33;
`ifdef BITLOGIC_POPCNT_EN
  logic [3:0]  c8;
  logic [4:0]  c16;
  logic [5:0]  c33;
`endif

  always #5 clk = ~clk;

  unidade_logica_nbits #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .op(op), .out_valid(ov8), .out_ready(out_ready),
    .resultado(r8), .zero(z8),
`ifdef BITLOGIC_POPCNT_EN
    .uns(u8), .contagem(c8)
`else
    .uns(u8)
`endif
  );

  unidade_logica_nbits #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
    .a(a[15:0]), .b(b[15:0]), .op(op), .out_valid(ov16), .out_ready(out_ready),
    .resultado(r16), .zero(z16),
`ifdef BITLOGIC_POPCNT_EN
    .uns(u16), .contagem(c16)
`else
    .uns(u16)
`endif
  );

  unidade_logica_nbits #(.WIDTH(33)) dut33 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir33),
    .a(a), .b(b), .op(op), .out_valid(ov33), .out_ready(out_ready),
    .resultado(r33), .zero(z33),
`ifdef BITLOGIC_POPCNT_EN
    .uns(u33), .contagem(c33)
`else
    .uns(u33)
`endif
  );

  typedef struct {
    logic [2:0]  op;
    logic [32:0] a;
    logic [32:0] b;
  } txn_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        zero;
    logic        uns;
  } vec_t;

  int          nvec = 0;
  int          nerr = 0;
  int          pops = 0;
  int          pops0;
  txn_t        q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_r16;
  logic [32:0] prev_r33;
  vec_t        vt[10];

  function automatic logic [32:0] model(input logic [2:0] o, input logic [32:0] x,
                                        input logic [32:0] y);
    case (o)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return ~(x | y);
      3'b011:  return x ^ y;
      3'b100:  return ~(x & y);
      3'b101:  return ~(x ^ y);
      3'b110:  return ~x;
      default: return x;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample at negedge, score transfers, advance past posedge
  task automatic tick();
    txn_t        t;
    logic [32:0] e;
    @(negedge clk);
    chk("in_ready_w8", 64'(ir8), 64'(ir16));
    chk("in_ready_w33", 64'(ir33), 64'(ir16));
    chk("out_valid_w8", 64'(ov8), 64'(ov16));
    chk("out_valid_w33", 64'(ov33), 64'(ov16));
    if (prev_stall) begin
      chk("stall_valid", 64'(ov16), 64'd1);
      chk("stall_r16", 64'(r16), 64'(prev_r16));
      chk("stall_r33", 64'(r33), 64'(prev_r33));
    end
    prev_stall = ov16 && !out_ready;
    prev_r16   = r16;
    prev_r33   = r33;
    if (ov16 && out_ready) begin
      pops++;
      chk("out_has_txn", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        t = q.pop_front();
        e = model(t.op, t.a, t.b);
        chk("res_w16", 64'(r16), 64'(e[15:0]));
        chk("zero_w16", 64'(z16), 64'(e[15:0] == 16'h0));
        chk("uns_w16", 64'(u16), 64'(&e[15:0]));
        chk("res_w8", 64'(r8), 64'(e[7:0]));
        chk("zero_w8", 64'(z8), 64'(e[7:0] == 8'h0));
        chk("uns_w8", 64'(u8), 64'(&e[7:0]));
        chk("res_w33", 64'(r33), 64'(e));
        chk("zero_w33", 64'(z33), 64'(e == 33'h0));
        chk("uns_w33", 64'(u33), 64'(&e));
`ifdef BITLOGIC_POPCNT_EN
        chk("cnt_w8", 64'(c8), 64'($countones(e[7:0])));
        chk("cnt_w16", 64'(c16), 64'($countones(e[15:0])));
        chk("cnt_w33", 64'(c33), 64'($countones(e)));
`endif
      end
    end
    if (in_valid && ir16) q.push_back('{op: op, a: a, b: b});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    op = 3'($urandom_range(0, 7));
    a  = 33'({$urandom, $urandom});
    b  = 33'({$urandom, $urandom});
  endtask

  initial begin
    vt[0] = '{3'b000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
    vt[1] = '{3'b001, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0};
    vt[2] = '{3'b010, 16'hF0F0, 16'hFF00, 16'h000F, 1'b0, 1'b0};
    vt[3] = '{3'b011, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0};
    vt[4] = '{3'b100, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b0, 1'b0};
    vt[5] = '{3'b101, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b0, 1'b0};
    vt[6] = '{3'b110, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b0, 1'b0};
    vt[7] = '{3'b111, 16'hF0F0, 16'hFF00, 16'hF0F0, 1'b0, 1'b0};
    vt[8] = '{3'b010, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vt[9] = '{3'b101, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'b000; a = '0; b = '0;
    #12;
    chk("rst_out_valid", 64'(ov16), 64'd0);
    chk("rst_res", 64'(r16), 64'h0);
    chk("rst_zero", 64'(z16), 64'd1);
    chk("rst_uns", 64'(u16), 64'd0);
    chk("rst_in_ready", 64'(ir16), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed ops and flags, one transaction at a time
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = vt[i].op;
      a = {17'h0, vt[i].a}; b = {17'h0, vt[i].b};
      tick();
      in_valid = 1'b0;
      chk("lat_early", 64'(ov16), 64'd0);
      tick();
      chk("lat_valid", 64'(ov16), 64'd1);
      chk("vec_res", 64'(r16), 64'(vt[i].res));
      chk("vec_zero", 64'(z16), 64'(vt[i].zero));
      chk("vec_uns", 64'(u16), 64'(vt[i].uns));
`ifdef BITLOGIC_POPCNT_EN
      if (i == 9) chk("vec_cnt16", 64'(c16), 64'd16);
`endif
      tick();
    end

    // Backpressure: two accepted, third held until out_ready returns
    out_ready = 1'b0; in_valid = 1'b1; op = 3'b011;
    a = 33'h1_0000_1111; b = 33'h0_0F0F_0F0F; tick();
    a = 33'h0_2222_2222; b = 33'h1_FFFF_0000; tick();
    a = 33'h1_3333_3333; b = 33'h0_0000_FFFF;
    chk("bp_in_ready", 64'(ir16), 64'd0);
    tick(); tick(); tick();
    chk("bp_out_valid", 64'(ov16), 64'd1);
    chk("bp_held", 64'(q.size()), 64'd2);
    pops0 = pops;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("bp_drained", 64'(pops - pops0), 64'd3);
    chk("bp_q_empty", 64'(q.size()), 64'd0);

    // Reset mid-stream with both stages full
    out_ready = 1'b0; in_valid = 1'b1;
    rand_in(); tick();
    rand_in(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(ov16), 64'd0);
    chk("mrst_res", 64'(r16), 64'h0);
    chk("mrst_res33", 64'(r33), 64'h0);
    chk("mrst_zero", 64'(z16), 64'd1);
    chk("mrst_uns", 64'(u16), 64'd0);
    chk("mrst_in_ready", 64'(ir16), 64'd1);
`ifdef BITLOGIC_POPCNT_EN
    chk("mrst_cnt", 64'(c16), 64'd0);
`endif
    q.delete();
    prev_stall = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("mrst_no_out", 64'(ov16), 64'd0);

    // Back-to-back streaming at full throughput
    pops0 = pops;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      rand_in();
      tick();
      if (i >= 1) chk("stream_valid", 64'(ov16), 64'd1);
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("stream_count", 64'(pops - pops0), 64'd100);

    // Random valid/ready toggling
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      rand_in();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("rand_q_empty", 64'(q.size()), 64'd0);
    chk("rand_idle", 64'(ov16), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
